// File: rtl/crc_share_arbiter.sv
// crc_share_arbiter: round-robin sharing of one serial CRC engine among NREQ requesters.
// Optional WAIT watchdog enabled by defining CRC_TIMEOUT_EN.
module crc_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int ID_W   = 2,
    parameter int KEY_W  = 32,
    parameter int CRC_W  = 32,
    parameter int TO_CYC = KEY_W + 8
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*KEY_W-1:0]   key,
    output logic [NREQ-1:0]         ack,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CRC_W-1:0]        rsp_crc,
    output logic                    rsp_err,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic                    crc_reset,
    output logic                    crc_start,
    output logic [KEY_W-1:0]        crc_key,
    input  logic                    crc_done,
    input  logic [CRC_W-1:0]        crc_code
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [NREQ-1:0]   ack_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [CRC_W-1:0]  rsp_crc_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic              crc_reset_q;
    logic              crc_start_q;
    logic [KEY_W-1:0]  crc_key_q;
    logic              hit_d;
    logic [ID_W-1:0]   win_d;
    logic [ID_W-1:0]   idx;
`ifdef CRC_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYC + 1);
    logic [WD_W-1:0]   wd_q;
`endif

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_crc   = rsp_crc_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign crc_reset = crc_reset_q;
    assign crc_start = crc_start_q;
    assign crc_key   = crc_key_q;

    // Walk downward in offset so the nearest set bit after the pointer wins.
    always_comb begin
        hit_d = 1'b0;
        win_d = ptr_q;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = ID_W'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) begin
                hit_d = 1'b1;
                win_d = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NREQ - 1);
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_crc_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            crc_reset_q <= 1'b1;
            crc_start_q <= 1'b0;
            crc_key_q   <= '0;
`ifdef CRC_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            crc_reset_q <= 1'b0;
            ack_q       <= '0;
            crc_start_q <= 1'b0;
            case (state_q)
                IDLE: if (hit_d) begin
                    state_q     <= LAUNCH;
                    ptr_q       <= win_d;
                    rsp_id_q    <= win_d;
                    crc_key_q   <= key[win_d*KEY_W +: KEY_W];
                    ack_q       <= NREQ'(1) << win_d;
                    crc_start_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
                LAUNCH: begin
                    state_q <= WAIT;
`ifdef CRC_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                WAIT: if (crc_done) begin
                    rsp_crc_q   <= crc_code;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    state_q     <= HOLD;
                end
`ifdef CRC_TIMEOUT_EN
                else if (wd_q == WD_W'(TO_CYC - 1)) begin
                    rsp_crc_q   <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    crc_reset_q <= 1'b1;
                    state_q     <= HOLD;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
`endif
                HOLD: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_share_arbiter.sv
// tb_crc_share_arbiter: randomized self-checking bench with a round-robin reference model
// and a CRC engine stub that raises Done KEY_W cycles after its Start edge.
module tb_crc_share_arbiter;
    localparam int NREQ   = 4;
    localparam int KEY_W  = 32;
    localparam int CRC_W  = 32;
    localparam int TO_CYC = KEY_W + 8;

    logic                  CLK = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*KEY_W-1:0] key;
    logic [NREQ-1:0]       ack;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [CRC_W-1:0]      rsp_crc;
    logic                  rsp_err;
    logic                  rsp_ready;
    logic                  busy;
    logic                  crc_reset;
    logic                  crc_start;
    logic [KEY_W-1:0]      crc_key;
    logic                  crc_done;
    logic [CRC_W-1:0]      crc_code;

    logic                  stub_en;
    int                    scnt;
    logic [KEY_W-1:0]      skey;
    int                    ptr_m;
    int                    n_tests = 0;
    int                    n_fail = 0;

    crc_share_arbiter dut (
        .CLK(CLK), .reset(reset), .req(req), .key(key), .ack(ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .busy(busy), .crc_reset(crc_reset), .crc_start(crc_start),
        .crc_key(crc_key), .crc_done(crc_done), .crc_code(crc_code)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (crc_reset) begin
            scnt     <= 0;
            crc_done <= 1'b0;
        end else if (crc_start) begin
            scnt     <= KEY_W;
            crc_done <= 1'b0;
            skey     <= crc_key;
        end else begin
            crc_done <= stub_en && scnt == 1;
            if (scnt > 0) scnt <= scnt - 1;
        end
    end
    assign crc_code = crc_done ? (32'hC0DE_0000 | {16'h0, skey[15:0]}) : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic rand_keys();
        for (int i = 0; i < NREQ; i++) key[i*KEY_W +: KEY_W] = $urandom;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] nr, input int hold, input bit pulse1, input bit to);
        int w, lat, bad, exp_id;
        logic [KEY_W-1:0] k;
        logic [CRC_W-1:0] c;
        logic [1:0] id;
        exp_id = rr_pick(ptr_m, req);
        w = 0;
        do begin @(negedge CLK); w++; end while (ack == 0 && w < 20);
        check("grant_wait", w, 1);
        check("ack", ack, 4'b0001 << exp_id);
        check("crc_start", crc_start, 1);
        k = key[exp_id*KEY_W +: KEY_W];
        check("crc_key", crc_key, k);
        ptr_m = exp_id;
        lat = 0;
        bad = 0;
        while (!rsp_valid && lat < TO_CYC + 20) begin
            @(negedge CLK);
            lat++;
            if (ack != 0 || crc_start || !busy || crc_key != k) bad++;
        end
        check("wait_quiet", bad, 0);
        check("latency", lat, to ? TO_CYC + 1 : KEY_W + 2);
        check("crc_reset_at_rsp", crc_reset, to);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_crc", rsp_crc, to ? 32'h0 : (32'hC0DE_0000 | {16'h0, k[15:0]}));
        check("rsp_err", rsp_err, to);
        id = rsp_id;
        c = rsp_crc;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                req = pulse1 ? 4'b0010 : nr;
                rand_keys();
            end else req = nr;
            @(negedge CLK);
            if (i == 0) check("crc_reset_pulse", crc_reset, 0);
            if (!rsp_valid || rsp_id != id || rsp_crc != c || rsp_err != to || ack != 0 || !busy) bad++;
        end
        check("hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("rsp_drop", {rsp_valid, busy, ack}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad;
        int order [5] = '{0, 1, 2, 3, 0};
        reset = 1'b0;
        req = '0;
        rsp_ready = 1'b0;
        stub_en = 1'b1;
        rand_keys();
        repeat (3) @(negedge CLK);
        check("rst_outs", {ack, rsp_valid, rsp_err, crc_start, busy}, 0);
        check("rst_data", {rsp_id, rsp_crc, crc_key}, 0);
        check("rst_crc_reset", crc_reset, 1);
        reset = 1'b1;
        #1 check("crc_reset_held", crc_reset, 1);
        @(negedge CLK);
        check("crc_reset_clear", crc_reset, 0);
        ptr_m = NREQ - 1;

        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(i == 4 ? 4'b0000 : 4'b1111, 1, 0, 0);
            check("rr_order", rsp_id, order[i]);
        end

        key[2*KEY_W +: KEY_W] = 32'h0000_1234;
        req = 4'b0100;
        run_txn(4'b0000, 2, 0, 0);
        check("t1_crc", rsp_crc, 32'hC0DE_1234);

        req = 4'b0001;
        run_txn(4'b0010, 10, 0, 0);
        run_txn(4'b0000, 1, 0, 0);

        req = 4'b0001;
        run_txn(4'b0000, 3, 1, 0);
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (ack != 0 || rsp_valid || busy) bad++;
        end
        check("no_spurious", bad, 0);

        req = 4'($urandom_range(1, 15));
        for (int i = 0; i < 30; i++)
            run_txn(i == 29 ? 4'b0000 : 4'($urandom_range(1, 15)), $urandom_range(1, 4), 0, 0);

        req = 4'b1000;
        bad = 0;
        do begin @(negedge CLK); bad++; end while (ack == 0 && bad < 20);
        check("t4_ack", ack, 4'b1000);
        req = '0;
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {ack, rsp_valid, rsp_err, crc_start, busy}, 0);
        check("mid_rst_data", {rsp_id, rsp_crc, crc_key}, 0);
        check("mid_rst_crc_reset", crc_reset, 1);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        #1 check("mid_crc_reset_held", crc_reset, 1);
        @(negedge CLK);
        check("mid_crc_reset_clear", crc_reset, 0);
        bad = 0;
        repeat (KEY_W + 5) begin
            @(negedge CLK);
            if (rsp_valid || busy) bad++;
        end
        check("mid_no_rsp", bad, 0);
        ptr_m = NREQ - 1;
        rand_keys();
        req = 4'b0001;
        run_txn(4'b0000, 1, 0, 0);

        stub_en = 1'b0;
        req = 4'b0010;
`ifdef CRC_TIMEOUT_EN
        run_txn(4'b0000, 2, 0, 1);
`else
        bad = 0;
        do begin @(negedge CLK); bad++; end while (ack == 0 && bad < 20);
        check("t5_ack", ack, 4'b0010);
        req = '0;
        bad = 0;
        repeat (TO_CYC + 10) begin
            @(negedge CLK);
            if (!busy || rsp_valid || rsp_err) bad++;
        end
        check("no_timeout_wait", bad, 0);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        ptr_m = NREQ - 1;
`endif
        stub_en = 1'b1;
        rand_keys();
        req = 4'b0100;
        run_txn(4'b0000, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
